// File: rtl/sal_sched_rw_pkg.sv
// Shared types for the sal_sched_rw DRAM command scheduler.
//   cmd_t  : command encoding driven on cmd_o (NOP/ACT/RD/WR/PRE)
//   mode_t : read/write drain mode of the scheduler
package sal_sched_pkg;

  typedef enum logic [2:0] {
    CMD_NOP = 3'd0,
    CMD_ACT = 3'd1,
    CMD_RD  = 3'd2,
    CMD_WR  = 3'd3,
    CMD_PRE = 3'd4
  } cmd_t;

  typedef enum logic {
    RD_MODE = 1'b0,
    WR_MODE = 1'b1
  } mode_t;

endpackage

// File: rtl/sal_sched_rw_if.sv
// Bank-controller <-> scheduler bus.
//   req_*_i  : per-bank command requests, held until granted
//   *_ok_i   : DRAM timing qualifiers per command class
//   gnt_o    : one-hot 1-cycle grant back to the chosen bank
//   cmd_*_o  : issued command towards the DDR command/address driver
//   wr_mode_o: 1 while the scheduler drains writes
// master = bank side (drives requests), slave = scheduler.
interface sal_sched_rw_if #(
  parameter int BK_CNT = 8,
  parameter int BA_W   = $clog2(BK_CNT)
);
  import sal_sched_pkg::*;

  logic [BK_CNT-1:0] req_act_i;
  logic [BK_CNT-1:0] req_rd_i;
  logic [BK_CNT-1:0] req_wr_i;
  logic [BK_CNT-1:0] req_pre_i;
  logic              act_ok_i;
  logic              rd_ok_i;
  logic              wr_ok_i;
  logic [BK_CNT-1:0] gnt_o;
  logic              cmd_vld_o;
  cmd_t              cmd_o;
  logic [BA_W-1:0]   cmd_ba_o;
  logic              wr_mode_o;

  modport master (
    output req_act_i, req_rd_i, req_wr_i, req_pre_i, act_ok_i, rd_ok_i, wr_ok_i,
    input  gnt_o, cmd_vld_o, cmd_o, cmd_ba_o, wr_mode_o
  );

  modport slave (
    input  req_act_i, req_rd_i, req_wr_i, req_pre_i, act_ok_i, rd_ok_i, wr_ok_i,
    output gnt_o, cmd_vld_o, cmd_o, cmd_ba_o, wr_mode_o
  );
endinterface

// File: rtl/sal_sched_rw_chk.sv
// Property checker for sal_sched_rw; attach alongside the scheduler.
//   clk, rst         : scheduler clock/reset
//   req_*            : bank request vectors
//   gnt, cmd_vld     : scheduler grant outputs
// A bank raising more than one request class at once is illegal.
module sal_sched_rw_chk #(
  parameter int BK_CNT = 8
) (
  input logic              clk,
  input logic              rst,
  input logic [BK_CNT-1:0] req_act,
  input logic [BK_CNT-1:0] req_rd,
  input logic [BK_CNT-1:0] req_wr,
  input logic [BK_CNT-1:0] req_pre,
  input logic [BK_CNT-1:0] gnt,
  input logic              cmd_vld
);

  for (genvar b = 0; b < BK_CNT; b++) begin : g_bank
    a_one_class: assert property (@(posedge clk) disable iff (rst)
      $onehot0({req_act[b], req_rd[b], req_wr[b], req_pre[b]}));
  end

  a_gnt_onehot: assert property (@(posedge clk) disable iff (rst) $onehot0(gnt));
  a_vld_gnt:    assert property (@(posedge clk) disable iff (rst) cmd_vld == (|gnt));

endmodule

// File: rtl/sal_sched_rw_rr_pick.sv
// Combinational round-robin picker.
//   req : request vector
//   ptr : bank to start searching at (search wraps N-1 -> 0)
//   gnt : one-hot winner, idx : winner index, vld : any request present
// With ptr tied to zero it degenerates into a lowest-index picker.
module sal_rr_pick #(
  parameter int N = 8,
  parameter int W = $clog2(N)
) (
  input  logic [N-1:0] req,
  input  logic [W-1:0] ptr,
  output logic [N-1:0] gnt,
  output logic [W-1:0] idx,
  output logic         vld
);

  // first request at or after ptr, then one-hot expansion of the winner
  always_comb begin
    int b;
    vld = 1'b0;
    idx = {W{1'b0}};
    gnt = {N{1'b0}};
    for (int k = 0; k < N; k++) begin
      b   = (int'(ptr) + k) % N;
      idx = (req[b] && !vld) ? W'(b) : idx;
      vld = vld | req[b];
    end
    for (int i = 0; i < N; i++) begin
      gnt[i] = vld & (idx == W'(i));
    end
  end

endmodule

// File: rtl/sal_sched_rw.sv
// DRAM command scheduler: picks at most one ACT/RD/WR/PRE per cycle across
// BK_CNT banks and returns a registered one-hot grant.
//   clk, rst : clock, synchronous active-high reset
//   bus      : sal_sched_rw_if slave (requests/timing in, grant/command out)
// Read/write drain mode with hysteresis, round-robin within a class and
// per-bank ageing; a starved eligible bank overrides class order and rr.
module sal_sched_rw
  import sal_sched_pkg::*;
#(
  parameter int BK_CNT  = 8,
  parameter int BA_W    = $clog2(BK_CNT),
  parameter int AGE_W   = 4,
  parameter int AGE_MAX = 15,
  parameter int WR_HI   = 4,
  parameter int WR_LO   = 1
) (
  input  logic          clk,
  input  logic          rst,
  sal_sched_rw_if.slave bus
);

  localparam int PEND_W = $clog2(BK_CNT + 1);
  localparam logic [AGE_W-1:0] AGE_SAT = AGE_W'(AGE_MAX);

  logic [BK_CNT-1:0] gnt_r;
  logic              cmd_vld_r;
  cmd_t              cmd_r;
  logic [BA_W-1:0]   cmd_ba_r;
  logic [BA_W-1:0]   rr_ptr_r;
  mode_t             mode_r, mode_nxt_s;
  logic [AGE_W-1:0]  age_r [BK_CNT];

  logic [BK_CNT-1:0] elig_act_s, elig_rd_s, elig_wr_s, elig_pre_s;
  logic [BK_CNT-1:0] any_req_s, starved_s, st_elig_s;
  logic [BK_CNT-1:0] gnt_act_s, gnt_rd_s, gnt_wr_s, gnt_pre_s, gnt_st_s;
  logic [BA_W-1:0]   idx_act_s, idx_rd_s, idx_wr_s, idx_pre_s, idx_st_s;
  logic              vld_act_s, vld_rd_s, vld_wr_s, vld_pre_s, vld_st_s;
  logic [PEND_W-1:0] wr_pend_s, rd_pend_s;
  logic              st_wr_any_s, st_rd_any_s;

  logic [BK_CNT-1:0] sel_gnt_s;
  logic              sel_vld_s;
  cmd_t              sel_cmd_s;
  logic [BA_W-1:0]   sel_ba_s;

  // the bank currently holding a grant is masked so its still-high req is not re-served
  assign elig_act_s = bus.req_act_i & ~gnt_r & {BK_CNT{bus.act_ok_i}};
  assign elig_rd_s  = bus.req_rd_i  & ~gnt_r & {BK_CNT{bus.rd_ok_i}};
  assign elig_wr_s  = bus.req_wr_i  & ~gnt_r & {BK_CNT{bus.wr_ok_i}};
  assign elig_pre_s = bus.req_pre_i & ~gnt_r;
  assign any_req_s  = bus.req_act_i | bus.req_rd_i | bus.req_wr_i | bus.req_pre_i;

  // starvation flags, restricted to classes allowed in the current mode
  always_comb begin
    for (int b = 0; b < BK_CNT; b++) begin
      starved_s[b] = (age_r[b] == AGE_SAT);
    end
    st_elig_s = starved_s & (elig_pre_s | elig_act_s |
                             ((mode_r == WR_MODE) ? elig_wr_s : elig_rd_s));
  end

  sal_rr_pick #(.N(BK_CNT), .W(BA_W)) u_pick_act (.req(elig_act_s), .ptr(rr_ptr_r), .gnt(gnt_act_s), .idx(idx_act_s), .vld(vld_act_s));
  sal_rr_pick #(.N(BK_CNT), .W(BA_W)) u_pick_rd  (.req(elig_rd_s),  .ptr(rr_ptr_r), .gnt(gnt_rd_s),  .idx(idx_rd_s),  .vld(vld_rd_s));
  sal_rr_pick #(.N(BK_CNT), .W(BA_W)) u_pick_wr  (.req(elig_wr_s),  .ptr(rr_ptr_r), .gnt(gnt_wr_s),  .idx(idx_wr_s),  .vld(vld_wr_s));
  sal_rr_pick #(.N(BK_CNT), .W(BA_W)) u_pick_pre (.req(elig_pre_s), .ptr(rr_ptr_r), .gnt(gnt_pre_s), .idx(idx_pre_s), .vld(vld_pre_s));
  sal_rr_pick #(.N(BK_CNT), .W(BA_W)) u_pick_st  (.req(st_elig_s),  .ptr({BA_W{1'b0}}), .gnt(gnt_st_s), .idx(idx_st_s), .vld(vld_st_s));

  // class mux: starved bank first, then CAS of the current mode > PRE > ACT
  always_comb begin
    sel_gnt_s = {BK_CNT{1'b0}};
    sel_vld_s = 1'b0;
    sel_cmd_s = CMD_NOP;
    sel_ba_s  = {BA_W{1'b0}};
    if (vld_st_s) begin
      sel_gnt_s = gnt_st_s;
      sel_vld_s = 1'b1;
      sel_ba_s  = idx_st_s;
      if ((mode_r == RD_MODE) && elig_rd_s[idx_st_s]) begin
        sel_cmd_s = CMD_RD;
      end else if ((mode_r == WR_MODE) && elig_wr_s[idx_st_s]) begin
        sel_cmd_s = CMD_WR;
      end else if (elig_pre_s[idx_st_s]) begin
        sel_cmd_s = CMD_PRE;
      end else begin
        sel_cmd_s = CMD_ACT;
      end
    end else if ((mode_r == RD_MODE) && vld_rd_s) begin
      sel_gnt_s = gnt_rd_s;
      sel_vld_s = 1'b1;
      sel_ba_s  = idx_rd_s;
      sel_cmd_s = CMD_RD;
    end else if ((mode_r == WR_MODE) && vld_wr_s) begin
      sel_gnt_s = gnt_wr_s;
      sel_vld_s = 1'b1;
      sel_ba_s  = idx_wr_s;
      sel_cmd_s = CMD_WR;
    end else if (vld_pre_s) begin
      sel_gnt_s = gnt_pre_s;
      sel_vld_s = 1'b1;
      sel_ba_s  = idx_pre_s;
      sel_cmd_s = CMD_PRE;
    end else if (vld_act_s) begin
      sel_gnt_s = gnt_act_s;
      sel_vld_s = 1'b1;
      sel_ba_s  = idx_act_s;
      sel_cmd_s = CMD_ACT;
    end else begin
      sel_vld_s = 1'b0;
    end
  end

  assign wr_pend_s   = PEND_W'($countones(bus.req_wr_i));
  assign rd_pend_s   = PEND_W'($countones(bus.req_rd_i));
  assign st_wr_any_s = |(starved_s & bus.req_wr_i);
  assign st_rd_any_s = |(starved_s & bus.req_rd_i);

  // mode FSM next state; a starved opposite-direction bank bypasses hysteresis
  always_comb begin
    mode_nxt_s = mode_r;
    case (mode_r)
      RD_MODE: begin
        if ((wr_pend_s >= PEND_W'(WR_HI)) ||
            ((rd_pend_s == {PEND_W{1'b0}}) && (wr_pend_s != {PEND_W{1'b0}})) ||
            st_wr_any_s) begin
          mode_nxt_s = WR_MODE;
        end else begin
          mode_nxt_s = RD_MODE;
        end
      end
      WR_MODE: begin
        if ((wr_pend_s == {PEND_W{1'b0}}) ||
            ((wr_pend_s <= PEND_W'(WR_LO)) && (rd_pend_s != {PEND_W{1'b0}})) ||
            st_rd_any_s) begin
          mode_nxt_s = RD_MODE;
        end else begin
          mode_nxt_s = WR_MODE;
        end
      end
      default: mode_nxt_s = RD_MODE;
    endcase
  end

  // output registers, rr pointer, mode state and age counters
  always_ff @(posedge clk) begin
    if (rst) begin
      gnt_r     <= {BK_CNT{1'b0}};
      cmd_vld_r <= 1'b0;
      cmd_r     <= CMD_NOP;
      cmd_ba_r  <= {BA_W{1'b0}};
      rr_ptr_r  <= {BA_W{1'b0}};
      mode_r    <= RD_MODE;
      for (int b = 0; b < BK_CNT; b++) begin
        age_r[b] <= {AGE_W{1'b0}};
      end
    end else begin
      gnt_r     <= sel_gnt_s;
      cmd_vld_r <= sel_vld_s;
      cmd_r     <= sel_cmd_s;
      mode_r    <= mode_nxt_s;
      if (sel_vld_s) begin
        cmd_ba_r <= sel_ba_s;
        rr_ptr_r <= (sel_ba_s == BA_W'(BK_CNT - 1)) ? {BA_W{1'b0}} : sel_ba_s + BA_W'(1);
      end
      for (int b = 0; b < BK_CNT; b++) begin
        if (sel_gnt_s[b] || !any_req_s[b]) begin
          age_r[b] <= {AGE_W{1'b0}};
        end else if (age_r[b] != AGE_SAT) begin
          age_r[b] <= age_r[b] + AGE_W'(1);
        end
      end
    end
  end

  assign bus.gnt_o     = gnt_r;
  assign bus.cmd_vld_o = cmd_vld_r;
  assign bus.cmd_o     = cmd_r;
  assign bus.cmd_ba_o  = cmd_ba_r;
  assign bus.wr_mode_o = (mode_r == WR_MODE);

endmodule

// File: tb/tb_sal_sched_rw.sv
module tb_sal_sched_rw;
  import sal_sched_pkg::*;

  localparam int BK_CNT = 8;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  sal_sched_rw_if #(.BK_CNT(BK_CNT)) bus ();

  sal_sched_rw #(.BK_CNT(BK_CNT)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  sal_sched_rw_chk #(.BK_CNT(BK_CNT)) u_chk (
    .clk     (clk),
    .rst     (rst),
    .req_act (bus.req_act_i),
    .req_rd  (bus.req_rd_i),
    .req_wr  (bus.req_wr_i),
    .req_pre (bus.req_pre_i),
    .gnt     (bus.gnt_o),
    .cmd_vld (bus.cmd_vld_o)
  );

  int err_cnt = 0;
  int chk_cnt = 0;
  logic [5:0] exp_q [$];   // {cmd, bank}

  task automatic check_val(input string tag, input logic [31:0] act, input logic [31:0] exp);
    chk_cnt++;
    if (act !== exp) begin
      err_cnt++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  task automatic push_exp(input cmd_t c, input int b);
    exp_q.push_back({c, 3'(b)});
  endtask

  // one clock; observe registered outputs on the falling edge, banks drop granted reqs
  task automatic tick();
    logic [5:0] e;
    logic [31:0] one;
    @(negedge clk);
    if (bus.cmd_vld_o) begin
      if (exp_q.size() == 0) begin
        check_val("unexpected_grant", 32'(bus.gnt_o), 32'd0);
      end else begin
        e   = exp_q.pop_front();
        one = 32'd1;
        check_val("gnt", 32'(bus.gnt_o), one << e[2:0]);
        check_val("cmd", 32'(bus.cmd_o), 32'(e[5:3]));
        check_val("ba",  32'(bus.cmd_ba_o), 32'(e[2:0]));
      end
      bus.req_act_i = bus.req_act_i & ~bus.gnt_o;
      bus.req_rd_i  = bus.req_rd_i  & ~bus.gnt_o;
      bus.req_wr_i  = bus.req_wr_i  & ~bus.gnt_o;
      bus.req_pre_i = bus.req_pre_i & ~bus.gnt_o;
    end else begin
      check_val("idle_gnt", 32'(bus.gnt_o), 32'd0);
      check_val("idle_cmd", 32'(bus.cmd_o), 32'(CMD_NOP));
    end
  endtask

  task automatic wait_drain(input string tag, input int budget);
    int n = 0;
    while (exp_q.size() != 0 && n < budget) begin
      tick();
      n++;
    end
    check_val(tag, 32'(exp_q.size()), 32'd0);
    exp_q.delete();
  endtask

  task automatic clear_inputs();
    bus.req_act_i = '0;
    bus.req_rd_i  = '0;
    bus.req_wr_i  = '0;
    bus.req_pre_i = '0;
    bus.act_ok_i  = 1'b0;
    bus.rd_ok_i   = 1'b0;
    bus.wr_ok_i   = 1'b0;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    clear_inputs();
    tick();
    tick();
    rst = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    // reset state
    rst = 1'b1;
    clear_inputs();
    tick();
    check_val("rst_gnt",  32'(bus.gnt_o), 32'd0);
    check_val("rst_vld",  32'(bus.cmd_vld_o), 32'd0);
    check_val("rst_cmd",  32'(bus.cmd_o), 32'(CMD_NOP));
    check_val("rst_ba",   32'(bus.cmd_ba_o), 32'd0);
    check_val("rst_mode", 32'(bus.wr_mode_o), 32'd0);
    tick();
    rst = 1'b0;

    // 1 single read, then no re-grant and bank address holds
    bus.req_rd_i = 8'h04;
    bus.rd_ok_i  = 1'b1;
    push_exp(CMD_RD, 2);
    tick();
    check_val("t1_lat", 32'(exp_q.size()), 32'd0);
    tick();
    check_val("t1_no_regrant", 32'(bus.gnt_o), 32'd0);
    check_val("t1_ba_hold", 32'(bus.cmd_ba_o), 32'd2);

    // 2 round-robin over all banks
    do_reset();
    bus.req_act_i = 8'hFF;
    bus.act_ok_i  = 1'b1;
    for (int i = 0; i < BK_CNT; i++) push_exp(CMD_ACT, i);
    wait_drain("t2_drain", 20);

    // 3 class order in RD mode
    do_reset();
    bus.req_rd_i  = 8'h02;
    bus.req_pre_i = 8'h04;
    bus.req_act_i = 8'h08;
    bus.rd_ok_i   = 1'b1;
    bus.act_ok_i  = 1'b1;
    push_exp(CMD_RD, 1);
    push_exp(CMD_PRE, 2);
    push_exp(CMD_ACT, 3);
    wait_drain("t3_drain", 10);

    // 4 write drain with hysteresis; RD held off for the first cycle only
    do_reset();
    bus.req_wr_i = 8'h0F;
    bus.req_rd_i = 8'h10;
    bus.wr_ok_i  = 1'b1;
    bus.rd_ok_i  = 1'b0;
    for (int i = 0; i < 4; i++) push_exp(CMD_WR, i);
    push_exp(CMD_RD, 4);
    tick();
    check_val("t4_wr_mode", 32'(bus.wr_mode_o), 32'd1);
    bus.rd_ok_i = 1'b1;
    wait_drain("t4_drain", 20);
    check_val("t4_rd_mode", 32'(bus.wr_mode_o), 32'd0);

    // 5 starvation: ACT b5 blocked for 15 cycles while reads alternate on b0/b1
    do_reset();
    bus.req_act_i = 8'h20;
    bus.req_rd_i  = 8'h03;
    bus.rd_ok_i   = 1'b1;
    bus.act_ok_i  = 1'b0;
    for (int k = 1; k <= 15; k++) push_exp(CMD_RD, (k % 2 == 1) ? 0 : 1);
    push_exp(CMD_ACT, 5);
    push_exp(CMD_RD, 0);
    push_exp(CMD_RD, 1);
    for (int k = 1; k <= 15; k++) begin
      tick();
      bus.req_rd_i = bus.req_rd_i | 8'h03;
    end
    bus.act_ok_i = 1'b1;
    wait_drain("t5_drain", 10);

    // 6 reset mid-operation drops the pending choice and the WR mode
    do_reset();
    bus.req_wr_i = 8'h0F;
    bus.wr_ok_i  = 1'b1;
    tick();
    check_val("t6_wr_mode", 32'(bus.wr_mode_o), 32'd1);
    rst = 1'b1;
    tick();
    check_val("t6_gnt",  32'(bus.gnt_o), 32'd0);
    check_val("t6_vld",  32'(bus.cmd_vld_o), 32'd0);
    check_val("t6_mode", 32'(bus.wr_mode_o), 32'd0);
    clear_inputs();
    tick();
    rst = 1'b0;
    bus.req_rd_i = 8'h03;
    bus.rd_ok_i  = 1'b1;
    push_exp(CMD_RD, 0);
    push_exp(CMD_RD, 1);
    wait_drain("t6_post", 10);

    $display("Result: errors=%0d of %0d checks", err_cnt, chk_cnt);
    $finish;
  end

endmodule
